cpu_run_monitor: RTL

Synthesisable, parametrised run monitor for the simple CPU family. Replaces the fixed-delay "run then dump" check with hardware that:
- observes the program counter and register-file write port;
- detects program completion (PC parked) or a timeout;
- keeps a shadow copy of the register file;
- reports cycle and write counts, final PC, and snapshot readback.

It sits beside the CPU core, wired to the PC output and regfile write port, and is used in simulation and on-chip bring-up.

---
 rtl/cpu_run_monitor.sv | 101 ++++++++++
 1 files changed

// File: rtl/cpu_run_monitor.sv
// Run monitor for the simple CPU family: watches PC and regfile writes, detects a parked PC
// (halt) or a cycle budget overrun (timeout), and keeps a shadow register file for readback.
module cpu_run_monitor #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned PC_W           = 4,
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned HALT_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned AW            = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [PC_W-1:0]   pc,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        state,
  output logic              done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  write_count,
  output logic [PC_W-1:0]   final_pc
);

  localparam int unsigned SW    = $clog2(HALT_CYCLES + 1);
  localparam int unsigned CMP_W = (CNT_W > 32) ? CNT_W : 32;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRun     = 2'b01,
    StHalted  = 2'b10,
    StTimeout = 2'b11
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cycle_count_q;
  logic [CNT_W-1:0]  write_count_q;
  logic [PC_W-1:0]   final_pc_q;
  logic [PC_W-1:0]   prev_pc_q;
  logic [SW-1:0]     stable_cnt_q;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];

  logic pc_same;
  logic halt_hit;
  logic timeout_hit;

  // stable_cnt + 1 >= HALT_CYCLES and cycle_count + 1 >= TIMEOUT_CYCLES, rewritten to avoid
  // overflow; the timeout compare is widened so a narrow counter never truncates the limit.
  assign pc_same     = (pc == prev_pc_q);
  assign halt_hit    = pc_same && (stable_cnt_q >= SW'(HALT_CYCLES - 1));
  assign timeout_hit = CMP_W'(cycle_count_q) >= CMP_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cycle_count_q <= '0;
      write_count_q <= '0;
      final_pc_q    <= '0;
      prev_pc_q     <= '0;
      stable_cnt_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else if (start) begin
      state_q       <= StRun;
      cycle_count_q <= '0;
      write_count_q <= '0;
      final_pc_q    <= '0;
      prev_pc_q     <= pc;
      stable_cnt_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else if (state_q == StRun) begin
      if (cycle_count_q != '1) cycle_count_q <= cycle_count_q + 1'b1;
      if (wr_en) begin
        shadow_q[wr_addr] <= wr_data;
        if (write_count_q != '1) write_count_q <= write_count_q + 1'b1;
      end
      stable_cnt_q <= pc_same ? stable_cnt_q + 1'b1 : '0;
      prev_pc_q    <= pc;
      // Halt takes priority when both conditions fire on the same edge.
      if (halt_hit) begin
        state_q    <= StHalted;
        final_pc_q <= pc;
      end else if (timeout_hit) begin
        state_q    <= StTimeout;
        final_pc_q <= pc;
      end
    end
  end

  assign state       = state_q;
  assign done        = state_q[1];
  assign timed_out   = (state_q == StTimeout);
  assign cycle_count = cycle_count_q;
  assign write_count = write_count_q;
  assign final_pc    = final_pc_q;
  assign rd_data     = shadow_q[rd_sel];

endmodule
